bitstream_window: RTL

Upstream bit-supply stage for the CAVLC residual decoders (coeff-token, level, total-zeros/run-before). It accepts 32-bit slice-data words MSB-first over a valid/ready handshake and buffers up to 64 bits. It presents the next 16 unconsumed bits as a register-direct window, and consumes a variable number of bits per cycle on request from whichever decoder stage currently owns the bitstream.

---
 rtl/bitstream_window.sv | 82 ++++++++
 1 files changed

// File: rtl/bitstream_window.sv
// bitstream_window: 64-bit left-aligned bit buffer feeding the CAVLC decoders.
// Accepts 32-bit words MSB-first and exposes the next 16 unconsumed bits as a
// register slice. A variable shift of 0..16 bits can be applied in the same
// cycle as a word load.
module bitstream_window (
   input  logic        Clk,
   input  logic        nReset,
   input  logic        Flush,
   input  logic [31:0] InData,
   input  logic        InValid,
   output logic        InReady,
   output logic [15:0] BitstreamShifted,
   output logic        WindowValid,
   input  logic [4:0]  NumShift,
   input  logic        ShiftEn,
   output logic [6:0]  BitCount,
   output logic [31:0] BitPos,
   output logic        ShiftError
);

   // Buffer state. r_buf is left-aligned (bit 63 oldest), and bits below
   // 64-r_cnt are kept at zero so an incoming word can simply be OR-ed in.
   logic [63:0] r_buf;
   logic [6:0]  r_cnt;
   logic [31:0] r_pos;
   logic        r_err;

   logic        w_legal;
   logic        w_illegal;
   logic        w_load;
   logic [4:0]  w_s;
   logic [6:0]  w_cnt_post;
   logic [63:0] w_buf_post;
   logic [63:0] w_word_aligned;

   // Ready depends only on fill level and Flush, so producers never see a
   // combinational path from the consumer's ShiftEn.
   assign InReady = (r_cnt <= 7'd32) && !Flush;

   // Outputs are direct register taps; the window has no logic in front of it.
   assign BitstreamShifted = r_buf[63:48];
   assign WindowValid      = (r_cnt >= 7'd16);
   assign BitCount         = r_cnt;
   assign BitPos           = r_pos;
   assign ShiftError       = r_err;

   // Decode the shift request, form the post-shift buffer and align the new word.
   always_comb begin
      w_legal        = ShiftEn && (NumShift <= 5'd16) && ({2'b00, NumShift} <= r_cnt);
      w_illegal      = ShiftEn && !w_legal;
      w_s            = w_legal ? NumShift : 5'd0;
      w_cnt_post     = r_cnt - {2'b00, w_s};
      w_buf_post     = r_buf << w_s;
      // A load only happens when r_cnt <= 32, so w_cnt_post <= 32 and the
      // word always lands fully inside the 64-bit buffer.
      w_word_aligned = {InData, 32'h0000_0000} >> w_cnt_post;
      w_load         = InValid && InReady;
   end

   // State update: Flush clears everything; otherwise shift, then append the word.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         r_buf <= '0;
         r_cnt <= '0;
         r_pos <= '0;
         r_err <= 1'b0;
      end else if (Flush) begin
         r_buf <= '0;
         r_cnt <= '0;
         r_pos <= '0;
         r_err <= 1'b0;
      end else begin
         r_buf <= w_load ? (w_buf_post | w_word_aligned) : w_buf_post;
         r_cnt <= w_load ? (w_cnt_post + 7'd32) : w_cnt_post;
         r_pos <= r_pos + {27'd0, w_s};
         if (w_illegal) begin
            r_err <= 1'b1;
         end
      end
   end

endmodule
